// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and FSM state encodings for the register file.
// Also provides the byte-lane merge used when committing strobed writes.
package axi_lite_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic data_t merge_bytes(data_t old_val, data_t new_val, strb_t strb);
        data_t result;
        result = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                result[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite signal bundle with master and slave views.
interface axi_lite_if
    import axi_lite_pkg::*;
;
    addr_t awaddr;
    logic  awvalid;
    logic  awready;
    data_t wdata;
    strb_t wstrb;
    logic  wvalid;
    logic  wready;
    resp_t bresp;
    logic  bvalid;
    logic  bready;
    addr_t araddr;
    logic  arvalid;
    logic  arready;
    data_t rdata;
    resp_t rresp;
    logic  rvalid;
    logic  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave terminating in a bank of 32-bit control/status registers.
// Define AXI_LITE_REGFILE_SLVERR_EN to answer out-of-range and read-only-write accesses with SLVERR.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                N_REGS    = 16,
    parameter addr_t             BASE_ADDR = 32'h0000_0000,
    parameter logic [N_REGS-1:0] RO_MASK   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_lite_if.slave            s,
    output logic [N_REGS*32-1:0] regs_o,
    output logic [N_REGS-1:0]    wr_pulse_o,
    input  logic [N_REGS*32-1:0] status_i
);

    localparam int          IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [32:0] SPAN  = 33'(N_REGS) << 2;

    wr_state_t wr_state;
    rd_state_t rd_state;
    data_t     regs_q [N_REGS];

    logic  aw_held, w_held;
    addr_t aw_addr_q;
    data_t w_data_q;
    strb_t w_strb_q;
    logic  awready_q, wready_q, bvalid_q;
    resp_t bresp_q;
    logic  arready_q, rvalid_q;
    resp_t rresp_q;
    data_t rdata_q;

    addr_t             wr_off, rd_off;
    logic              wr_hit, rd_hit, wr_ro, rd_ro, wr_err, rd_err;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    data_t             rd_value;

    assign wr_off = aw_addr_q - BASE_ADDR;
    assign wr_hit = (aw_addr_q >= BASE_ADDR) && ({1'b0, wr_off} < SPAN);
    assign wr_idx = wr_off[IDX_W+1:2];
    assign wr_ro  = RO_MASK[wr_idx];

    assign rd_off = s.araddr - BASE_ADDR;
    assign rd_hit = (s.araddr >= BASE_ADDR) && ({1'b0, rd_off} < SPAN);
    assign rd_idx = rd_off[IDX_W+1:2];
    assign rd_ro  = RO_MASK[rd_idx];

`ifdef AXI_LITE_REGFILE_SLVERR_EN
    assign wr_err = !wr_hit || wr_ro;
    assign rd_err = !rd_hit;
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    // Read-only registers report live status; anything outside the window reads as zero.
    always_comb begin
        rd_value = '0;
        if (rd_hit) begin
            rd_value = rd_ro ? status_i[{rd_idx, 5'b0} +: 32] : regs_q[rd_idx];
        end
    end

    // Write path: collect AW and W in either order, commit one cycle later, then hold B.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state   <= WR_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_o <= '0;
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_pulse_o <= '0;
            case (wr_state)
                WR_IDLE: begin
                    if (aw_held && w_held) begin
                        if (wr_hit && !wr_ro) begin
                            regs_q[wr_idx]     <= merge_bytes(regs_q[wr_idx], w_data_q, w_strb_q);
                            wr_pulse_o[wr_idx] <= 1'b1;
                        end
                        bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                        bvalid_q  <= 1'b1;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        wr_state  <= WR_RESP;
                    end else begin
                        if (s.awvalid && awready_q) begin
                            aw_addr_q <= s.awaddr;
                            aw_held   <= 1'b1;
                            awready_q <= 1'b0;
                        end
                        if (s.wvalid && wready_q) begin
                            w_data_q <= s.wdata;
                            w_strb_q <= s.wstrb;
                            w_held   <= 1'b1;
                            wready_q <= 1'b0;
                        end
                    end
                end
                WR_RESP: begin
                    if (s.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_state  <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read path: one outstanding read, data registered at the AR handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (s.arvalid) begin
                        rdata_q   <= rd_value;
                        rresp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rd_state  <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_state  <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rresp   = rresp_q;
    assign s.rdata   = rdata_q;

    for (genvar i = 0; i < N_REGS; i++) begin : g_regs
        assign regs_o[32*i +: 32] = regs_q[i];
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed cases plus randomized reads/writes
// compared against an array-based register model.
module tb_axi_lite_regfile;
    import axi_lite_pkg::*;

    localparam logic [15:0] RO = 16'h8000;
`ifdef AXI_LITE_REGFILE_SLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] regs_o;
    logic [15:0]  wr_pulse_o;
    logic [511:0] status_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model        [16];
    logic [31:0] status_model [16];

    axi_lite_if bus ();

    axi_lite_regfile #(
        .N_REGS    (16),
        .BASE_ADDR (32'h0000_0000),
        .RO_MASK   (RO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (bus),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o),
        .status_i   (status_i)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit inRange(input logic [31:0] addr);
        return addr < 32'd64;
    endfunction

    function automatic logic [511:0] modelFlat();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (!RO[i]) r[32*i +: 32] = model[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        int idx;
        if (!inRange(addr)) return 32'h0;
        idx = int'(addr / 4);
        return RO[idx] ? status_model[idx] : model[idx];
    endfunction

    task automatic clearModel;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    // lead > 0: W is offered that many cycles before AW; lead < 0: AW goes first.
    task automatic writeTxn(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead);
        int          aw_start, w_start, cyc, lat, idx;
        bit          aw_done, w_done, aw_fire, w_fire, bad;
        logic [15:0] exp_pulse;
        logic [1:0]  exp_resp;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        aw_done = 0; w_done = 0; cyc = 0; lat = 0;
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.awvalid = !aw_done && (cyc >= aw_start);
            bus.wvalid  = !w_done && (cyc >= w_start);
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            tick;
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        checkOutput("wr_handshake", {aw_done, w_done}, 2'b11);

        exp_pulse = '0;
        bad = !inRange(addr);
        if (!bad) begin
            idx = int'(addr / 4);
            if (RO[idx]) begin
                bad = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
                exp_pulse[idx] = 1'b1;
            end
        end
        exp_resp = (ERR_EN && bad) ? 2'b10 : 2'b00;

        checkOutput("b_early", bus.bvalid, 1'b0);
        while (!bus.bvalid && lat < 10) begin
            tick;
            lat++;
        end
        checkOutput("b_latency", lat, 1);
        checkOutput("bresp", bus.bresp, exp_resp);
        checkOutput("wr_pulse", wr_pulse_o, exp_pulse);
        checkOutput("regs", regs_o, modelFlat());
        checkOutput("awready_in_resp", bus.awready, 1'b0);
        bus.bready = 1'b1;
        tick;
        bus.bready = 1'b0;
        checkOutput("b_clear", bus.bvalid, 1'b0);
        checkOutput("pulse_clear", wr_pulse_o, 16'h0);
        checkOutput("awready_back", bus.awready, 1'b1);
    endtask

    task automatic readTxn(input logic [31:0] addr, input int stall);
        int          cyc;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        cyc = 0;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!bus.arready && cyc < 20) begin
            tick;
            cyc++;
        end
        checkOutput("ar_ready", bus.arready, 1'b1);
        exp_data = modelRead(addr);
        exp_resp = (ERR_EN && !inRange(addr)) ? 2'b10 : 2'b00;
        tick;
        bus.arvalid = 1'b0;
        checkOutput("rvalid", bus.rvalid, 1'b1);
        checkOutput("rdata", bus.rdata, exp_data);
        checkOutput("rresp", bus.rresp, exp_resp);
        for (int s = 0; s < stall; s++) begin
            tick;
            checkOutput("r_hold_valid", bus.rvalid, 1'b1);
            checkOutput("r_hold_data", bus.rdata, exp_data);
            checkOutput("arready_busy", bus.arready, 1'b0);
        end
        bus.rready = 1'b1;
        tick;
        bus.rready = 1'b0;
        checkOutput("r_clear", bus.rvalid, 1'b0);
        checkOutput("arready_back", bus.arready, 1'b1);
    endtask

    task automatic applyStimulus(input bit is_write, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb, input int arg);
        if (is_write) writeTxn(addr, data, strb, arg);
        else          readTxn(addr, arg);
    endtask

    // Linear directed sequence followed by a randomized phase and reset corner cases.
    initial begin
        rst = 1'b1;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        for (int i = 0; i < 16; i++) status_model[i] = $urandom;
        status_model[15] = 32'hCAFE_0001;
        for (int i = 0; i < 16; i++) status_i[32*i +: 32] = status_model[i];
        clearModel();
        tick;
        tick;
        rst = 1'b0;

        checkOutput("rst_awready", bus.awready, 1'b1);
        checkOutput("rst_wready", bus.wready, 1'b1);
        checkOutput("rst_arready", bus.arready, 1'b1);
        checkOutput("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        checkOutput("rst_resps", {bus.bresp, bus.rresp}, 4'h0);
        checkOutput("rst_rdata", bus.rdata, 32'h0);
        checkOutput("rst_pulse", wr_pulse_o, 16'h0);
        checkOutput("rst_regs", regs_o, 512'h0);

        $display("[TB] directed cases");
        applyStimulus(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 0);
        checkOutput("reg2_value", regs_o[95:64], 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h04, 32'h1122_3344, 4'b0101, 3);
        checkOutput("reg1_strobed", regs_o[63:32], 32'h0022_0044);
        applyStimulus(1'b1, 32'h10, 32'h5555_AAAA, 4'hF, -2);
        applyStimulus(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0);
        checkOutput("reg4_nostrb", regs_o[159:128], 32'h5555_AAAA);
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 5);
        applyStimulus(1'b1, 32'h3C, 32'h1234_5678, 4'hF, 0);
        applyStimulus(1'b0, 32'h3C, 32'h0, 4'h0, 0);
        applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 1);
        applyStimulus(1'b1, 32'h44, 32'h0BAD_F00D, 4'hF, 1);
        applyStimulus(1'b0, 32'h0B, 32'h0, 4'h0, 0);

        $display("[TB] randomized phase");
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 19) * 4) | $urandom_range(0, 3);
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 6) - 3 + 3 * 0);
        end

        $display("[TB] reset during write response");
        bus.awaddr = 32'h0C; bus.wdata = 32'h0102_0304; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tick;
        checkOutput("pre_rst_bvalid", bus.bvalid, 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clearModel();
        checkOutput("post_rst_bvalid", bus.bvalid, 1'b0);
        checkOutput("post_rst_awready", bus.awready, 1'b1);
        checkOutput("post_rst_regs", regs_o, 512'h0);

        $display("[TB] reset on commit cycle");
        bus.awaddr = 32'h14; bus.wdata = 32'hA5A5_A5A5; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("commit_rst_regs", regs_o, modelFlat());
        checkOutput("commit_rst_pulse", wr_pulse_o, 16'h0);
        checkOutput("commit_rst_bvalid", bus.bvalid, 1'b0);
        tick;
        checkOutput("commit_rst_late", {bus.bvalid, wr_pulse_o}, 17'h0);
        applyStimulus(1'b1, 32'h14, 32'h0000_00FF, 4'b0001, 0);
        applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
